// File: rtl/input_port_scanner_if.sv
// Pin-event handshake between the input port scanner (master) and the CPU core (slave).
interface input_port_scanner_if;
   logic       evt_valid;
   logic [1:0] evt_pin;
   logic       evt_level;
   logic       evt_ack;

   modport master (output evt_valid, output evt_pin, output evt_level, input evt_ack);
   modport slave  (input evt_valid, input evt_pin, input evt_level, output evt_ack);
endinterface

// File: rtl/input_port_scanner.sv
// Synchronises pins D4..D7, queues level changes as pending flags and presents them round-robin.
// Optional build macro DEBOUNCE_EN adds a per-pin hold-time filter of DEB_CYCLES cycles.
module input_port_scanner #(
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            pin_d,
   input_port_scanner_if.master  evt_if,
   output logic [3:0]            pin_level,
   output logic                  irq
);

   typedef enum logic {IDLE, PRESENT} state_e;

   if (DEB_CYCLES < 1 || DEB_CYCLES > 15 || DEB_CYCLES >= (1 << DEB_W)) begin : g_deb_range
      $error("input_port_scanner: DEB_CYCLES out of range for DEB_W");
   end

   state_e     state_q, state_d;
   logic [3:0] sync1_q, sync1_d;
   logic [3:0] sync2_q, sync2_d;
   logic [3:0] stable_q, stable_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] set_chg;
   logic [3:0] pend_clr;
   logic [1:0] last_grant_q, last_grant_d;
   logic [1:0] evt_pin_q, evt_pin_d;
   logic       evt_level_q, evt_level_d;
   logic [1:0] winner;
   logic       found;

   // Stage 1-2: two-flop synchroniser
   always_comb begin
      sync1_d = pin_d;
      sync2_d = sync1_q;
   end

   // Stage 3: change detect into the accepted level
`ifdef DEBOUNCE_EN
   logic [DEB_W-1:0] deb_cnt_q [4];
   logic [DEB_W-1:0] deb_cnt_d [4];

   always_comb begin
      stable_d = stable_q;
      set_chg  = '0;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
               stable_d[i] = sync2_q[i];
               set_chg[i]  = 1'b1;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) deb_cnt_q[i] <= '0;
         else     deb_cnt_q[i] <= deb_cnt_d[i];
      end
   end
`else
   always_comb begin
      stable_d = sync2_q;
      set_chg  = sync2_q ^ stable_q;
   end
`endif

   // Round-robin search starting just after the last granted pin
   always_comb begin
      winner = last_grant_q;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && pending_q[last_grant_q + 2'(k)]) begin
            winner = last_grant_q + 2'(k);
            found  = 1'b1;
         end
      end
   end

   // Stage 4: grant/ack FSM; a new change on the acked pin outranks the clear
   always_comb begin
      state_d      = state_q;
      evt_pin_d    = evt_pin_q;
      evt_level_d  = evt_level_q;
      last_grant_d = last_grant_q;
      pend_clr     = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = PRESENT;
               evt_pin_d   = winner;
               evt_level_d = stable_q[winner];
            end
         end
         PRESENT: begin
            if (evt_if.evt_ack) begin
               state_d             = IDLE;
               pend_clr[evt_pin_q] = 1'b1;
               last_grant_d        = evt_pin_q;
            end
         end
      endcase
      pending_d = (pending_q & ~pend_clr) | set_chg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         pending_q    <= '0;
         state_q      <= IDLE;
         last_grant_q <= 2'd3;
         evt_pin_q    <= '0;
         evt_level_q  <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         pending_q    <= pending_d;
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         evt_pin_q    <= evt_pin_d;
         evt_level_q  <= evt_level_d;
      end
   end

   assign evt_if.evt_valid = (state_q == PRESENT);
   assign evt_if.evt_pin   = evt_pin_q;
   assign evt_if.evt_level = evt_level_q;
   assign pin_level        = stable_q;
   assign irq              = (|pending_q) | (state_q == PRESENT);

endmodule

// File: tb/tb_input_port_scanner.sv
// Randomised and directed bench for input_port_scanner against a sample-history reference model.
module tb_input_port_scanner;
`ifdef DEBOUNCE_EN
   localparam int DEB = 4;
`else
   localparam int DEB = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] pin_d = 4'b0000;
   logic [3:0] pin_level;
   logic       irq;

   input_port_scanner_if evt_if ();

   input_port_scanner #(.DEB_CYCLES(4), .DEB_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .pin_d     (pin_d),
      .evt_if    (evt_if),
      .pin_level (pin_level),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   // Reference model: pin sample history plus the event queue state
   logic [3:0] hist [16];
   logic [3:0] m_stable, m_pend;
   logic       m_valid, m_lvl;
   logic [1:0] m_pin;
   int         m_last;

   logic [1:0] got_pin [$];
   logic       got_lvl [$];

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model across the coming rising edge using the inputs it will sample.
   task automatic model_step();
      logic [3:0] nstab, setm, clr;
      bit ok;
      if (rst) begin
         foreach (hist[j]) hist[j] = '0;
         m_stable = '0; m_pend = '0; m_valid = 0; m_pin = '0; m_lvl = 0; m_last = 3;
         return;
      end
      for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pin_d;
      nstab = m_stable; setm = '0; clr = '0;
      // a pin is accepted once the DEB most recent synchronised samples all disagree with it
      for (int i = 0; i < 4; i++) begin
         ok = 1;
         for (int j = 2; j <= DEB + 1; j++) if (hist[j][i] == m_stable[i]) ok = 0;
         if (ok) begin setm[i] = 1'b1; nstab[i] = hist[2][i]; end
      end
      if (m_valid) begin
         if (evt_if.evt_ack) begin clr[m_pin] = 1'b1; m_valid = 0; m_last = m_pin; end
      end else if (m_pend != 0) begin
         for (int k = 1; k <= 4; k++) begin
            if (!m_valid && m_pend[(m_last + k) % 4]) begin
               m_valid = 1;
               m_pin   = 2'((m_last + k) % 4);
               m_lvl   = m_stable[(m_last + k) % 4];
            end
         end
      end
      m_pend   = (m_pend & ~clr) | setm;
      m_stable = nstab;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk_val("evt_valid", evt_if.evt_valid, m_valid);
            chk_val("evt_pin",   evt_if.evt_pin,   m_pin);
            chk_val("evt_level", evt_if.evt_level, m_lvl);
            chk_val("pin_level", pin_level,        m_stable);
            chk_val("irq",       irq,              (|m_pend) | m_valid);
         end
         model_step();
         chk_en = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (!evt_if.evt_valid && cyc < budget) begin tick(); cyc++; end
      chk_val(tag, evt_if.evt_valid, 1);
   endtask

   task automatic drain(input int budget);
      int idle_run;
      idle_run = 0;
      got_pin.delete(); got_lvl.delete();
      for (int c = 0; c < budget && idle_run < 8 + DEB; c++) begin
         if (evt_if.evt_valid && !evt_if.evt_ack) begin
            evt_if.evt_ack = 1'b1;
            got_pin.push_back(evt_if.evt_pin);
            got_lvl.push_back(evt_if.evt_level);
         end else begin
            evt_if.evt_ack = 1'b0;
         end
         idle_run = (evt_if.evt_valid || irq) ? 0 : idle_run + 1;
         tick();
      end
      evt_if.evt_ack = 1'b0;
      chk_val("drain_done", idle_run >= 8 + DEB, 1);
   endtask

   initial begin
      int cyc;
      evt_if.evt_ack = 1'b0;
      do_reset();

      // single pin, first event latency, hold without ack
      pin_d = 4'b0100;
      wait_valid("t1_valid", 20, cyc);
      chk_val("t1_latency", cyc, 3 + DEB);
      repeat (10) tick();
      chk_val("t1_hold", {evt_if.evt_valid, evt_if.evt_pin, evt_if.evt_level}, 4'b1101);
      evt_if.evt_ack = 1'b1; tick(); evt_if.evt_ack = 1'b0;
      chk_val("t1_valid_off", evt_if.evt_valid, 0);
      chk_val("t1_irq_off", irq, 0);

      // round-robin order from reset, then restart after last_grant=3
      pin_d = 4'b0000;
      do_reset();
      drain(50);
      pin_d = 4'b1111;
      drain(100);
      chk_val("t2_n", got_pin.size(), 4);
      for (int i = 0; i < 4 && i < got_pin.size(); i++) begin
         chk_val("t2_pin", got_pin[i], i);
         chk_val("t2_lvl", got_lvl[i], 1);
      end
      pin_d = 4'b0000;
      drain(100);
      pin_d = 4'b0011;
      drain(100);
      chk_val("t2b_n", got_pin.size(), 2);
      for (int i = 0; i < 2 && i < got_pin.size(); i++) chk_val("t2b_pin", got_pin[i], i);

      // coalescing of D7 toggles while D4 is presented
      pin_d = 4'b0000;
      drain(100);
      pin_d = 4'b0001;
      wait_valid("t3_valid", 20, cyc);
      pin_d = 4'b1001; repeat (5) tick();
      pin_d = 4'b0001; repeat (5) tick();
      pin_d = 4'b1001; repeat (5) tick();
      drain(100);
      chk_val("t3_n", got_pin.size(), 2);
      if (got_pin.size() == 2) begin
         chk_val("t3_pin", got_pin[1], 3);
         chk_val("t3_lvl", got_lvl[1], 1);
      end
      pin_d = 4'b0000;
      drain(100);

      // new change landing on the ack edge keeps pending set
      pin_d = 4'b0010;
      wait_valid("t4_valid", 20, cyc);
      chk_val("t4_pin", evt_if.evt_pin, 1);
      pin_d = 4'b0000;
      tick();
      repeat (DEB) tick();
      evt_if.evt_ack = 1'b1; tick(); evt_if.evt_ack = 1'b0;
      chk_val("t4_valid_off", evt_if.evt_valid, 0);
      chk_val("t4_irq_pend", irq, 1);
      drain(100);
      chk_val("t4_n", got_pin.size(), 1);
      if (got_pin.size() == 1) begin
         chk_val("t4_pin2", got_pin[0], 1);
         chk_val("t4_lvl2", got_lvl[0], 0);
      end

      // reset mid-handshake with three pins pending
      pin_d = 4'b1110;
      wait_valid("t5_valid", 20, cyc);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_val("t5_outs", {evt_if.evt_valid, evt_if.evt_pin, evt_if.evt_level, pin_level, irq}, 0);
      drain(100);
      chk_val("t5_relearn", got_pin.size(), 3);
      pin_d = 4'b0000;
      drain(100);

`ifdef DEBOUNCE_EN
      // short glitch rejected, long pulse accepted
      pin_d = 4'b0100; repeat (3) tick();
      pin_d = 4'b0000; repeat (12) tick();
      chk_val("t6_glitch_lvl", pin_level[2], 0);
      chk_val("t6_glitch_irq", irq, 0);
      pin_d = 4'b0100;
      wait_valid("t6_valid", 30, cyc);
      chk_val("t6_latency", cyc, 7);
      pin_d = 4'b0000;
      drain(100);
`endif

      // random pin activity, random acks and occasional resets
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) pin_d = pin_d ^ (4'b0001 << $urandom_range(0, 3));
         evt_if.evt_ack = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      evt_if.evt_ack = 1'b0;
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
